// File: rtl/score_disp_pkg.sv
// Shared constants and types for the PONG score display: active-high segment
// patterns, digit-slot indices and the packed four-digit score word.
package score_disp_pkg;

  // Active-high segment patterns, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [1:0] IDX_P2_ONES = 2'd0;
  localparam logic [1:0] IDX_P2_TENS = 2'd1;
  localparam logic [1:0] IDX_P1_ONES = 2'd2;
  localparam logic [1:0] IDX_P1_TENS = 2'd3;

  // {p1_q1, p1_q0, p2_q1, p2_q0}: nibble n holds the digit shown in slot n.
  typedef logic [15:0] score_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_score_display.sv
// Four-digit multiplexed score display with slot blanking and frame-aligned commit.
// Define SCORE_LZ_BLANK_EN to blank tens digits that are zero.
module bcd_score_display
  import score_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 3000,
  parameter int unsigned BLANK_CYC  = 60,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       upd,
  input  logic [3:0] p1_q0,
  input  logic [3:0] p1_q1,
  input  logic [3:0] p2_q0,
  input  logic [3:0] p2_q1,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame
);

  localparam int unsigned     CntW     = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYC);
  localparam logic [6:0]      SegOff   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]      AnOff    = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  score_t          stage_q, stage_d, disp_q, disp_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            frame_q, frame_d;

  logic            tick, wrap, lz_d;
  logic [3:0]      digit_d, an_hi;
  logic [6:0]      seg_hi;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_d),
    .seg_o (seg_hi)
  );

  // Outputs are registered from next-state values so that seg/dp change on the
  // very cycle the new slot starts, well ahead of the anode after blanking.
  always_comb begin
    tick      = (cnt_q == CntLast);
    wrap      = tick && (idx_q == IDX_P1_TENS);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    stage_d   = upd ? score_t'({p1_q1, p1_q0, p2_q1, p2_q0}) : stage_q;
    pending_d = upd || (pending_q && !wrap);
    // Commit uses the stage value from before this edge, even if upd is high now.
    disp_d    = (wrap && pending_q) ? stage_q : disp_q;
    digit_d   = disp_d[{idx_d, 2'b00} +: 4];
`ifdef SCORE_LZ_BLANK_EN
    lz_d      = ((idx_d == IDX_P1_TENS) || (idx_d == IDX_P2_TENS)) && (digit_d == 4'd0);
`else
    lz_d      = 1'b0;
`endif
    an_hi     = ((cnt_d >= CntBlank) && !lz_d) ? (4'b0001 << idx_d) : 4'b0000;
    an_d      = ACTIVE_LOW ? ~an_hi : an_hi;
    seg_d     = lz_d ? SegOff : (ACTIVE_LOW ? ~seg_hi : seg_hi);
    dp_d      = (idx_d == IDX_P1_ONES) ^ ACTIVE_LOW;
    frame_d   = (cnt_d == CntLast) && (idx_d == IDX_P1_TENS);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      stage_q   <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SegOff;
      dp_q      <= ACTIVE_LOW;
      an_q      <= AnOff;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Bench for bcd_score_display: time-indexed reference model plus directed and random scores.
module tb_bcd_score_display;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] p1_q0 = '0, p1_q1 = '0, p2_q0 = '0, p2_q1 = '0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame;

  always #5 clk = ~clk;

  bcd_score_display #(
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .upd   (upd),
    .p1_q0 (p1_q0),
    .p1_q1 (p1_q1),
    .p2_q0 (p2_q0),
    .p2_q1 (p2_q1),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .frame (frame)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lz_on();
`ifdef SCORE_LZ_BLANK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Model: k = clock edges since reset release; slot and position follow from k.
  int          k;
  bit          live;
  logic [15:0] m_stage, m_disp;
  bit          m_pend;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      k <= 0; live <= 1'b0; m_stage <= '0; m_disp <= '0; m_pend <= 1'b0;
    end else begin
      if ((k % (4 * SD)) == (4 * SD - 1) && m_pend) m_disp <= m_stage;
      if (upd) begin
        m_stage <= {p1_q1, p1_q0, p2_q1, p2_q0};
        m_pend  <= 1'b1;
      end else if ((k % (4 * SD)) == (4 * SD - 1)) begin
        m_pend <= 1'b0;
      end
      k    <= k + 1;
      live <= 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    int         cnt, slot;
    logic [3:0] digit, oh;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_fr, lz;
    if (!live) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      cnt   = k % SD;
      slot  = (k / SD) % 4;
      digit = m_disp[slot*4 +: 4];
      lz    = lz_on() && (slot % 2 == 1) && (digit == 4'd0);
      oh    = 4'b0001 << slot;
      e_an  = (cnt >= BC && !lz) ? ~oh : 4'hF;
      e_seg = lz ? 7'h7F : ~seg_hi(digit);
      e_dp  = (slot != 2);
      e_fr  = (cnt == SD - 1) && (slot == 3);
    end
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_frame", 32'(frame), 32'(e_fr));
  end

  task automatic wait_at(input int c, input int s);
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (live && (k % SD) == c && ((k / SD) % 4) == s) ok = 1'b1;
    end
    chk("wait_reach", 32'(ok), 32'd1);
  endtask

  task automatic pulse(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    upd = 1'b1; p1_q1 = a3; p1_q0 = a2; p2_q1 = a1; p2_q0 = a0;
    @(negedge clk);
    upd = 1'b0;
  endtask

  initial begin
    int nfr;
    bit an3_seen;

    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_dp", 32'(dp), 32'd1);
    chk("reset_frame", 32'(frame), 32'd0);
    #1 clr = 1'b1;

    wait_at(2, 0);
    chk("rel_an0", 32'(an), 32'hE);
    chk("rel_seg0", 32'(seg), 32'h40);

    nfr = 0;
    repeat (96) begin
      @(negedge clk);
      if (frame) nfr++;
    end
    chk("frame_count", 32'(nfr), 32'd3);

    // Basic update 42 / 07
    wait_at(4, 1);
    pulse(4'd4, 4'd2, 4'd0, 4'd7);
    wait_at(3, 3);
    chk("hold_seg", 32'(seg), lz_on() ? 32'h7F : 32'h40);
    wait_at(3, 0);
    chk("basic_s0_seg", 32'(seg), 32'h78);
    chk("basic_s0_an", 32'(an), 32'hE);
    wait_at(3, 2);
    chk("basic_s2_seg", 32'(seg), 32'h24);
    chk("basic_s2_dp", 32'(dp), 32'd0);
    chk("basic_s2_an", 32'(an), 32'hB);
    wait_at(3, 3);
    chk("basic_s3_seg", 32'(seg), 32'h19);
    chk("basic_s3_an", 32'(an), 32'h7);

    // Tear-free: 12 then 99 in one frame
    wait_at(4, 0);
    pulse(4'd1, 4'd2, 4'd1, 4'd2);
    wait_at(4, 2);
    pulse(4'd9, 4'd9, 4'd9, 4'd9);
    wait_at(3, 3);
    chk("tear_old_seg", 32'(seg), 32'h19);
    wait_at(3, 3);
    chk("tear_new_seg", 32'(seg), 32'h10);

    // upd on the wrap cycle
    wait_at(4, 1);
    pulse(4'd3, 4'd3, 4'd3, 4'd3);
    wait_at(7, 3);
    pulse(4'd5, 4'd5, 4'd5, 4'd5);
    wait_at(3, 3);
    chk("simul_first_seg", 32'(seg), 32'h30);
    wait_at(3, 3);
    chk("simul_second_seg", 32'(seg), 32'h12);

    // Invalid BCD in slot 0
    wait_at(4, 1);
    pulse(4'd0, 4'd0, 4'd0, 4'hC);
    wait_at(4, 0);
    chk("dash_seg", 32'(seg), 32'h3F);
    chk("dash_an", 32'(an), 32'hE);

    // Mid-slot reset with an update pending
    wait_at(4, 1);
    pulse(4'd8, 4'd8, 4'd8, 4'd8);
    wait_at(4, 2);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("clr_seg", 32'(seg), 32'h7F);
    chk("clr_an", 32'(an), 32'hF);
    chk("clr_dp", 32'(dp), 32'd1);
    chk("clr_frame", 32'(frame), 32'd0);
    repeat (2) @(negedge clk);
    #1 clr = 1'b1;
    wait_at(3, 3);
    chk("post_clr_seg", 32'(seg), lz_on() ? 32'h7F : 32'h40);
    chk("post_clr_an", 32'(an), lz_on() ? 32'hF : 32'h7);
    wait_at(3, 3);
    chk("pend_drop_seg", 32'(seg), lz_on() ? 32'h7F : 32'h40);

    // Leading-zero case: p1=05, p2=10
    wait_at(4, 1);
    pulse(4'd0, 4'd5, 4'd1, 4'd0);
    wait_at(7, 3);
    an3_seen = 1'b0;
    nfr = 0;
    repeat (32) begin
      @(negedge clk);
      if (an[3] == 1'b0) an3_seen = 1'b1;
      if (frame) nfr++;
    end
    chk("lz_an3_active", 32'(an3_seen), lz_on() ? 32'd0 : 32'd1);
    chk("lz_frame_count", 32'(nfr), 32'd1);
    wait_at(3, 0);
    chk("lz_s0_seg", 32'(seg), 32'h40);
    wait_at(3, 1);
    chk("lz_s1_seg", 32'(seg), 32'h79);
    wait_at(3, 2);
    chk("lz_s2_seg", 32'(seg), 32'h12);

    // Random updates with occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      upd = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        upd   = 1'b1;
        p1_q1 = 4'($urandom_range(0, 15));
        p1_q0 = 4'($urandom_range(0, 15));
        p2_q1 = 4'($urandom_range(0, 15));
        p2_q0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clk);
        #2 clr = 1'b0;
        upd = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 clr = 1'b1;
      end
    end
    upd = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
